seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle radix-2 restoring integer divider, WIDTH-bit, unsigned or signed per request.
//   Computes the quotient and remainder for any divisor, including divide-by-zero and signed overflow.
//   Uses a start/busy/done handshake and sits beside the ALU as a shared long-latency execution unit.
// PARAMETERS
//   WIDTH      16  operand, quotient and remainder width in bits (>=4)
//   SIGNED_EN  1   1: honour is_signed; 0: is_signed ignored, all ops unsigned
// PORTS
//   clk          in   1      rising-edge clock, sole clock domain
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request; sampled only while idle (busy=0)
//   is_signed    in   1      1 = two's-complement operands, sampled with start
//   dividend     in   WIDTH  numerator, sampled with start
//   divisor      in   WIDTH  denominator, sampled with start
//   busy         out  1      high while an accepted operation is in flight
//   done         out  1      one-cycle pulse: results valid this cycle and held afterwards
//   quotient     out  WIDTH  quotient of last completed op
//   remainder    out  WIDTH  remainder of last completed op
//   div_by_zero  out  1      set with done if divisor==0, cleared at next accepted start
// BEHAVIOUR
//   - Reset: one clock; reset is synchronous and active-high. rst=1 at an edge forces state IDLE,
//     busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clears the iteration counter.
//     Reset mid-operation aborts the op; no done follows.
//   - FSM: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE. done is a registered pulse emitted
//     on the FIX->IDLE edge, so done and busy are never high together.
//   - Acceptance: start=1 in IDLE at edge E captures operands and mode. Inputs after E are ignored.
//     start while busy=1 is dropped and is not queued.
//   - PREP (1 cycle): signed op -> take magnitudes and latch quotient sign (dividend^divisor MSB)
//     and remainder sign (dividend MSB). divisor==0 -> skip ITER and FIX.
//   - ITER: each cycle shift {rem,quo} left by 1, trial-subtract |divisor| at WIDTH+1 bits,
//     keep the difference if it is non-negative, set quo LSB = ~borrow. A counter of
//     ceil(log2(WIDTH+1)) bits ends ITER after exactly WIDTH cycles.
//   - FIX (1 cycle): negate the quotient and/or remainder per the latched signs, modulo 2^WIDTH.
//     FIX is always spent, so latency does not depend on mode.
//   - Latency: start high in cycle 0 -> busy in cycles 1..WIDTH+2 -> done in cycle WIDTH+3.
//     Divide-by-zero: busy in cycle 1 only, done in cycle 2.
//   - Signed semantics: quotient truncates toward zero; remainder takes the dividend's sign;
//     dividend == quotient*divisor + remainder (mod 2^WIDTH).
//   - Divide by zero: quotient = all ones, remainder = dividend (unmodified), div_by_zero=1.
//   - Signed overflow MIN/-1: quotient = MIN (0x8000 at 16b), remainder = 0, no flag.
//   - Back-to-back: IDLE is entered on the done edge, so start high in the done cycle is accepted.
//     quotient/remainder keep their old values until the new done.
// TESTING (WIDTH=16, SIGNED_EN=1, start in cycle 0)
//   1. unsigned 1000/7 -> done in cycle 19, quotient=142, remainder=6, div_by_zero=0.
//   2. signed 0xFFF9(-7)/2 -> quotient=0xFFFD(-3), remainder=0xFFFF(-1); 7/0xFFFE -> q=0xFFFD, r=1.
//   3. 0x1234/0 (either mode) -> done in cycle 2, quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
//   4. signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0; same operands unsigned -> q=0, r=0x8000.
//   5. start pulsed again in cycle 5 with other operands -> ignored, first result intact;
//      rst in cycle 8 -> no done, outputs 0; a fresh op afterwards completes normally.
//   6. 65535/255 unsigned, then start in its done cycle with 255/255 -> q=257 r=0, then q=1 r=0
//      at cycles 19 and 38.

Source files
------------

// File: rtl/seq_divider_if.sv
// Request/response bundle for the shared sequential divider.
// The master issues operands with start; the slave reports busy, done and the results.
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, unsigned or two's-complement per request.
// Signed ops divide magnitudes and fix up signs afterwards, so the latency is the same in every mode.
module seq_divider #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   busy_c;

    // Operands captured at acceptance
    logic signed [WIDTH-1:0] dvd_in;
    logic signed [WIDTH-1:0] dvs_in;
    logic                    op_signed;

    // Iteration datapath
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dvs_mag;
    logic             q_neg;
    logic             r_neg;
    logic [CNT_W-1:0] cnt;

    // Architectural results
    logic             done_r;
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] rem_out;
    logic             dbz_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             dvs_zero;

    // |MIN| wraps back to MIN, which is exactly the unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic sgn);
        logic [WIDTH-1:0] u;
        u = $unsigned(v);
        return (sgn && v[WIDTH-1]) ? (~u + WIDTH'(1)) : u;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    assign dvs_zero = (dvs_in == '0);

    // Trial subtraction: shifted partial remainder (WIDTH+1 bits) against |divisor|.
    // The kept difference is always below |divisor|, so WIDTH bits hold it.
    always_comb begin
        shifted = {rem_acc, quo_acc[WIDTH-1]};
        borrow  = (shifted < {1'b0, dvs_mag});
        diff    = shifted[WIDTH-1:0] - dvs_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = PREP;
            end
            PREP: begin
                busy_c    = 1'b1;
                state_nxt = dvs_zero ? IDLE : ITER;
            end
            ITER: begin
                busy_c = 1'b1;
                if (cnt == LAST_ITER) state_nxt = FIX;
            end
            FIX: begin
                busy_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control and result registers: cleared by reset, results held between ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            done_r  <= 1'b0;
            quo_out <= '0;
            rem_out <= '0;
            dbz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.start) dbz_r <= 1'b0;
                end
                PREP: begin
                    if (dvs_zero) begin
                        quo_out <= '1;
                        rem_out <= $unsigned(dvd_in);
                        dbz_r   <= 1'b1;
                        done_r  <= 1'b1;
                    end
                end
                ITER: begin
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    quo_out <= apply_sign(quo_acc, q_neg);
                    rem_out <= apply_sign(rem_acc, r_neg);
                    done_r  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Data-only registers: meaningful only while the FSM is busy, so no reset.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (bus.start) begin
                    dvd_in    <= $signed(bus.dividend);
                    dvs_in    <= $signed(bus.divisor);
                    op_signed <= SIGNED_EN && bus.is_signed;
                end
            end
            PREP: begin
                quo_acc <= magnitude(dvd_in, op_signed);
                rem_acc <= '0;
                dvs_mag <= magnitude(dvs_in, op_signed);
                q_neg   <= op_signed & (dvd_in[WIDTH-1] ^ dvs_in[WIDTH-1]);
                r_neg   <= op_signed & dvd_in[WIDTH-1];
            end
            ITER: begin
                rem_acc <= borrow ? shifted[WIDTH-1:0] : diff;
                quo_acc <= {quo_acc[WIDTH-2:0], ~borrow};
            end
            default: ;
        endcase
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_out;
    assign bus.remainder   = rem_out;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=16): directed ops push expected results and
// done cycles; a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           at;
        string        name;
    } exp_t;

    exp_t sb[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive start for one cycle; the cycle of the driving edge is cycle 0.
    task automatic issue(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic edbz, input int lat,
                         input bit expect_done);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        if (expect_done) begin
            e.q    = eq;
            e.r    = er;
            e.dbz  = edbz;
            e.at   = cyc + lat;
            e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                done_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done at cycle %0d, no op outstanding", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_q"}, 32'(bus.quotient), 32'(e.q));
                    chk({e.name, "_r"}, 32'(bus.remainder), 32'(e.r));
                    chk({e.name, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
                    chk({e.name, "_busy_low"}, 32'(bus.busy), 32'd0);
                end
            end
        end
    end

    initial begin
        int seen;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_q", 32'(bus.quotient), 0);
        chk("rst_r", 32'(bus.remainder), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);

        // 1: unsigned 1000/7 with busy/done timing probes
        issue("u1000_7", 1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 19, 1'b1);
        chk("t1_busy_c1", 32'(bus.busy), 1);
        repeat (17) @(posedge clk);
        #1;
        chk("t1_busy_c18", 32'(bus.busy), 1);
        chk("t1_done_c18", 32'(bus.done), 0);
        @(posedge clk);
        #1;
        chk("t1_busy_c19", 32'(bus.busy), 0);
        chk("t1_done_c19", 32'(bus.done), 1);

        // 2: signed truncation toward zero
        issue("s_m7_2", 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 19, 1'b1);
        repeat (19) @(posedge clk);
        issue("s_7_m2", 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 19, 1'b1);
        repeat (19) @(posedge clk);

        // 3: divide by zero in both modes, negative dividend left unmodified
        issue("u_dbz", 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 2, 1'b1);
        repeat (3) @(posedge clk);
        issue("s_dbz", 1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 2, 1'b1);
        repeat (3) @(posedge clk);
        issue("s_dbz_neg", 1'b1, 16'h8001, 16'h0000, 16'hFFFF, 16'h8001, 1'b1, 2, 1'b1);
        repeat (3) @(posedge clk);

        // 4: MIN/-1 signed overflow, and the same bits unsigned
        issue("s_min_m1", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 19, 1'b1);
        repeat (19) @(posedge clk);
        issue("u_8000_ffff", 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 19, 1'b1);
        repeat (19) @(posedge clk);

        // 5a: start pulsed while busy is dropped
        issue("u256_16", 1'b0, 16'h0100, 16'h0010, 16'd16, 16'd0, 1'b0, 19, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);

        // 5b: reset in cycle 8 aborts the op without a done
        issue("abort", 1'b0, 16'd50000, 16'd3, 16'd0, 16'd0, 1'b0, 19, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_q", 32'(bus.quotient), 0);
        chk("abort_r", 32'(bus.remainder), 0);
        chk("abort_dbz", 32'(bus.div_by_zero), 0);
        seen = done_count;
        repeat (25) @(posedge clk);
        chk("abort_no_done", 32'(done_count - seen), 0);

        // 5c: fresh signed op after the abort
        issue("s_m100_7", 1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 19, 1'b1);
        repeat (19) @(posedge clk);

        // 6: back-to-back, second start in the first op's done cycle
        issue("u65535_255", 1'b0, 16'hFFFF, 16'h00FF, 16'd257, 16'd0, 1'b0, 19, 1'b1);
        repeat (17) @(posedge clk);
        issue("u255_255", 1'b0, 16'h00FF, 16'h00FF, 16'd1, 16'd0, 1'b0, 19, 1'b1);
        chk("b2b_busy", 32'(bus.busy), 1);
        chk("b2b_q_held", 32'(bus.quotient), 257);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d ops without done, required 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
